// File: rtl/data_memory_if.sv
// Core-to-data-memory request/response bundle.
// The core drives requests through the master modport; data_memory uses the slave modport.
interface data_memory_if;
  logic        iReq;
  logic        iWe;
  logic [2:0]  iFunct3;
  logic [31:0] iAddr;
  logic [31:0] iWrData;
  logic        oReady;
  logic        oRdValid;
  logic [31:0] oRdData;
  logic        oMisalign;

  modport master (
    output iReq, iWe, iFunct3, iAddr, iWrData,
    input  oReady, oRdValid, oRdData, oMisalign
  );

  modport slave (
    input  iReq, iWe, iFunct3, iAddr, iWrData,
    output oReady, oRdValid, oRdData, oMisalign
  );
endinterface

// File: rtl/data_memory.sv
// Byte-addressable data memory with one-cycle loads and single-edge stores.
// Optional macro DMEM_MISALIGN_TRAP_EN traps misaligned halfword/word accesses.
module data_memory #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic          iClk,
  input  logic          iRst_n,
  data_memory_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [0:0] {IDLE = 1'b0, READ = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        misalign_q, misalign_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          load_acc;
  logic          store_en;
  logic          misalign;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [31:0]   wr_rep;
  logic [31:0]   rd_word;
  logic          unused_addr;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      3'b010:  r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  assign unused_addr = ^bus.iAddr[31:AW+2];
  assign bus.oReady  = (state_q == IDLE);

  // Decode request: address split, byte enables, misalignment and store replication
  always_comb begin
    accept   = bus.iReq && (state_q == IDLE);
    load_acc = accept && !bus.iWe;
    idx      = bus.iAddr[AW+1:2];
    off      = bus.iAddr[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = ((bus.iFunct3[1:0] == 2'b01) && off[0]) ||
               ((bus.iFunct3 == 3'b010) && (off != 2'b00));
`else
    misalign = 1'b0;
`endif
    case (bus.iFunct3)
      3'b000:  be = 4'b0001 << off;
      3'b001:  be = off[1] ? 4'b1100 : 4'b0011;
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    case (bus.iFunct3)
      3'b000:  wr_rep = {4{bus.iWrData[7:0]}};
      3'b001:  wr_rep = {2{bus.iWrData[15:0]}};
      default: wr_rep = bus.iWrData;
    endcase
    store_en = accept && bus.iWe && !misalign && iRst_n;
    rd_word  = mem[idx];
  end

  // Byte-lane memory write; no reset so contents survive iRst_n
  always_ff @(posedge iClk) begin
    if (store_en) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) begin
          mem[idx][8*l +: 8] <= wr_rep[8*l +: 8];
        end
      end
    end
  end

  // State register
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: loads spend exactly one cycle in READ
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = load_acc ? READ : IDLE;
      READ:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: load result is computed at the accept edge and then held
  always_comb begin
    rd_valid_d = load_acc;
    misalign_d = accept && misalign;
    if (load_acc) begin
      rd_data_d = misalign ? 32'h0000_0000 : load_extend(rd_word, off, bus.iFunct3);
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Output registers
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'h0000_0000;
      misalign_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.oRdValid  = rd_valid_q;
  assign bus.oRdData   = rd_data_q;
  assign bus.oMisalign = misalign_q;
endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; expected values are hand-computed.
module tb_data_memory;
  logic iClk;
  logic iRst_n;
  int   errors;
  int   checks;

  data_memory_if bus ();

  data_memory #(.DEPTH_WORDS(256)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    @(negedge iClk);
    bus.iReq = 1'b1; bus.iWe = 1'b1; bus.iAddr = addr; bus.iWrData = data; bus.iFunct3 = f3;
    @(posedge iClk); #1;
    bus.iReq = 1'b0; bus.iWe = 1'b0;
  endtask

  // Load with latency/ready/hold checks; mis is the expected misalign flag
  task automatic load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                      input logic [31:0] exp, input logic mis);
    @(negedge iClk);
    bus.iReq = 1'b1; bus.iWe = 1'b0; bus.iAddr = addr; bus.iFunct3 = f3;
    @(posedge iClk); #1;
    bus.iReq = 1'b0;
    @(negedge iClk);
    chk({tag, "_valid"}, {31'd0, bus.oRdValid}, 32'd1);
    chk({tag, "_data"}, bus.oRdData, exp);
    chk({tag, "_ready"}, {31'd0, bus.oReady}, 32'd0);
    chk({tag, "_mis"}, {31'd0, bus.oMisalign}, {31'd0, mis});
    @(negedge iClk);
    chk({tag, "_vlow"}, {31'd0, bus.oRdValid}, 32'd0);
    chk({tag, "_hold"}, bus.oRdData, exp);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.iReq = 1'b0; bus.iWe = 1'b0; bus.iFunct3 = 3'b010;
    bus.iAddr = 32'h0; bus.iWrData = 32'h0;
    iRst_n = 1'b0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    chk("rst_ready", {31'd0, bus.oReady}, 32'd1);
    chk("rst_valid", {31'd0, bus.oRdValid}, 32'd0);
    chk("rst_mis", {31'd0, bus.oMisalign}, 32'd0);
    chk("rst_data", bus.oRdData, 32'h0);
    iRst_n = 1'b1;

    store(32'h0000_0010, 32'hDEAD_BEEF, 3'b010);
    load("lw10", 32'h0000_0010, 3'b010, 32'hDEAD_BEEF, 1'b0);

    store(32'h0000_0013, 32'h0000_0080, 3'b000);
    load("lb13", 32'h0000_0013, 3'b000, 32'hFFFF_FF80, 1'b0);
    load("lbu13", 32'h0000_0013, 3'b100, 32'h0000_0080, 1'b0);
    load("lw10b", 32'h0000_0010, 3'b010, 32'h80AD_BEEF, 1'b0);

    store(32'h0000_0020, 32'h1122_3344, 3'b010);
    store(32'h0000_0022, 32'h0000_8001, 3'b001);
    load("lh22", 32'h0000_0022, 3'b001, 32'hFFFF_8001, 1'b0);
    load("lhu22", 32'h0000_0022, 3'b101, 32'h0000_8001, 1'b0);
    load("lw20", 32'h0000_0020, 3'b010, 32'h8001_3344, 1'b0);

    store(32'h0000_0400, 32'h1234_5678, 3'b010);
    load("wrap", 32'h0000_0000, 3'b010, 32'h1234_5678, 1'b0);

    store(32'h0000_0000, 32'hFFFF_FFFF, 3'b011);
    load("undef_st", 32'h0000_0000, 3'b010, 32'h1234_5678, 1'b0);
    load("undef_ld", 32'h0000_0000, 3'b110, 32'h0000_0000, 1'b0);

    // Store to a misaligned word address
    store(32'h0000_0011, 32'hCAFE_F00D, 3'b010);
    @(negedge iClk);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("sw_mis_pulse", {31'd0, bus.oMisalign}, 32'd1);
    @(negedge iClk);
    chk("sw_mis_low", {31'd0, bus.oMisalign}, 32'd0);
    load("sw_mis_word", 32'h0000_0010, 3'b010, 32'h80AD_BEEF, 1'b0);
    load("lh_mis", 32'h0000_0013, 3'b001, 32'h0000_0000, 1'b1);
`else
    chk("sw_mis_pulse", {31'd0, bus.oMisalign}, 32'd0);
    load("sw_mis_word", 32'h0000_0010, 3'b010, 32'hCAFE_F00D, 1'b0);
    load("lh_round", 32'h0000_0013, 3'b001, 32'hFFFF_CAFE, 1'b0);
`endif

    // A request presented while in READ is ignored
    store(32'h0000_0030, 32'hAAAA_5555, 3'b010);
    @(negedge iClk);
    bus.iReq = 1'b1; bus.iWe = 1'b0; bus.iAddr = 32'h0000_0030; bus.iFunct3 = 3'b010;
    @(posedge iClk); #1;
    bus.iWe = 1'b1; bus.iWrData = 32'h0000_0000;
    @(posedge iClk); #1;
    bus.iReq = 1'b0; bus.iWe = 1'b0;
    load("busy_ign", 32'h0000_0030, 3'b010, 32'hAAAA_5555, 1'b0);

    // Reset during READ aborts the load
    @(negedge iClk);
    bus.iReq = 1'b1; bus.iWe = 1'b0; bus.iAddr = 32'h0000_0000; bus.iFunct3 = 3'b010;
    @(posedge iClk); #1;
    bus.iReq = 1'b0;
    iRst_n = 1'b0;
    @(posedge iClk); #1;
    iRst_n = 1'b1;
    @(negedge iClk);
    chk("abort_valid", {31'd0, bus.oRdValid}, 32'd0);
    chk("abort_data", bus.oRdData, 32'h0);
    chk("abort_ready", {31'd0, bus.oReady}, 32'd1);

    // Store presented during reset is discarded
    @(negedge iClk);
    iRst_n = 1'b0;
    bus.iReq = 1'b1; bus.iWe = 1'b1; bus.iAddr = 32'h0000_0000;
    bus.iWrData = 32'h0BAD_F00D; bus.iFunct3 = 3'b010;
    @(posedge iClk); #1;
    bus.iReq = 1'b0; bus.iWe = 1'b0;
    iRst_n = 1'b1;
    load("rst_store", 32'h0000_0000, 3'b010, 32'h1234_5678, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
